// File: rtl/dsi_crc_pkg.sv
// Shared constants and state encoding for the DSI CRC-16 engine.
package dsi_crc_pkg;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dsi_crc_step.sv
// One byte of the reflected CRC-16 (0x8408); passes crc_in through when en is low.
module dsi_crc_step
    import dsi_crc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    input  logic        en,
    output logic [15:0] crc_out
);

    logic [15:0] crc_work;

    // NOTE: combinational logic uses blocking '=' and assigns every output on every
    // path first, so no latch can be inferred.
    always_comb begin
        crc_work = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY_REFL) : (crc_work >> 1);
        end
        crc_out = en ? crc_work : crc_in;
    end

endmodule

// File: rtl/dsi_crc_engine.sv
// DSI packet checksum engine, LANES bytes per beat. Optional receive-side compare
// (rx_crc_i / crc_err_o) is enabled by defining DSI_CRC_CHECK_EN.
module dsi_crc_engine
    import dsi_crc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [8*LANES-1:0] data_i,
    input  logic [LANES-1:0]   keep_i,
    input  logic               last_i,
    output logic [15:0]        crc_o,
    output logic               crc_valid_o,
    output logic               busy_o
`ifdef DSI_CRC_CHECK_EN
    ,
    input  logic [15:0]        rx_crc_i,
    output logic               crc_err_o
`endif
);

    state_t           state;
    logic             accepted;
    logic [15:0]      crc_seed;
    logic [15:0]      crc_next;
    logic [LANES-1:0] lane_en;

    assign accepted = valid_i && (start_i || (state == RUN));
    assign crc_seed = start_i ? CRC_INIT : crc_o;
    assign busy_o   = (state == RUN);

    // Only the unbroken run of keep bits from lane 0 upward is folded.
    always_comb begin
        logic run;
        run     = 1'b1;
        lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            run        = run & keep_i[k];
            lane_en[k] = run;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [15:0] crc_in;
        logic [15:0] crc_out;

        if (k == 0) begin : g_first
            assign crc_in = crc_seed;
        end else begin : g_next
            assign crc_in = g_lane[k-1].crc_out;
        end

        dsi_crc_step u_step (
            .crc_in  (crc_in),
            .data    (data_i[8*k +: 8]),
            .en      (lane_en[k]),
            .crc_out (crc_out)
        );
    end

    assign crc_next = g_lane[LANES-1].crc_out;

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            crc_o       <= CRC_INIT;
            crc_valid_o <= 1'b0;
`ifdef DSI_CRC_CHECK_EN
            crc_err_o   <= 1'b0;
`endif
        end else begin
            crc_valid_o <= 1'b0;
`ifdef DSI_CRC_CHECK_EN
            crc_err_o   <= 1'b0;
`endif
            if (accepted) begin
                crc_o <= crc_next;
                if (last_i) begin
                    state       <= IDLE;
                    crc_valid_o <= 1'b1;
`ifdef DSI_CRC_CHECK_EN
                    crc_err_o   <= (crc_next != rx_crc_i);
`endif
                end else begin
                    state <= RUN;
                end
            end else if (start_i) begin
                crc_o <= CRC_INIT;
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_dsi_crc_engine.sv
// Directed bench for dsi_crc_engine: one LANES=1 and one LANES=4 instance.
module tb_dsi_crc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_valid = 1'b0, a_last = 1'b0;
    logic [7:0]  a_data  = '0;
    logic [0:0]  a_keep  = 1'b1;
    logic [15:0] a_crc;
    logic        a_crc_valid, a_busy;

    logic        b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic [31:0] b_data  = '0;
    logic [3:0]  b_keep  = '0;
    logic [15:0] b_crc;
    logic        b_crc_valid, b_busy;

`ifdef DSI_CRC_CHECK_EN
    logic [15:0] a_rx = '0, b_rx = '0;
    logic        a_err, b_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int base;
    logic [15:0] exp_crc;
    logic [7:0]  msg [9];

    always #5 clk = ~clk;

    dsi_crc_engine #(.LANES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .valid_i(a_valid),
        .data_i(a_data), .keep_i(a_keep), .last_i(a_last),
        .crc_o(a_crc), .crc_valid_o(a_crc_valid), .busy_o(a_busy)
`ifdef DSI_CRC_CHECK_EN
        , .rx_crc_i(a_rx), .crc_err_o(a_err)
`endif
    );

    dsi_crc_engine #(.LANES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .valid_i(b_valid),
        .data_i(b_data), .keep_i(b_keep), .last_i(b_last),
        .crc_o(b_crc), .crc_valid_o(b_crc_valid), .busy_o(b_busy)
`ifdef DSI_CRC_CHECK_EN
        , .rx_crc_i(b_rx), .crc_err_o(b_err)
`endif
    );

    always @(posedge clk) begin
        if (a_crc_valid === 1'b1) pulses_a <= pulses_a + 1;
        if (b_crc_valid === 1'b1) pulses_b <= pulses_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: one input bit per LFSR shift.
    function automatic logic [15:0] model(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    task automatic drive_a(input logic st, input logic v, input logic [7:0] d, input logic l);
        @(negedge clk);
        a_start = st; a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic drive_b(input logic st, input logic v, input logic [31:0] d,
                           input logic [3:0] k, input logic l);
        @(negedge clk);
        b_start = st; b_valid = v; b_data = d; b_keep = k; b_last = l;
    endtask

    task automatic send_msg_a();
        for (int i = 0; i < 9; i++) begin
            drive_a(i == 0, 1'b1, msg[i], i == 8);
            if (i == 1) begin
                check("a_busy_mid", a_busy, 1'b1);
                check("a_crc_byte0", a_crc, model(16'hFFFF, msg[0]));
            end
        end
    endtask

    task automatic send_msg_b(input logic [15:0] rx);
`ifdef DSI_CRC_CHECK_EN
        b_rx = rx;
`else
        if (rx != 16'h0) exp_crc = rx;
`endif
        drive_b(1'b1, 1'b1, 32'h34333231, 4'hF, 1'b0);
        drive_b(1'b0, 1'b1, 32'h38373635, 4'hF, 1'b0);
        drive_b(1'b0, 1'b1, 32'hAABBCC39, 4'b0001, 1'b1);
    endtask

    initial begin
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_crc", a_crc, 16'hFFFF);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_valid", a_crc_valid, 1'b0);
        check("rst_b_crc", b_crc, 16'hFFFF);
        check("rst_b_busy", b_busy, 1'b0);
        rst = 1'b0;

        // Beat in IDLE without start is ignored
        drive_a(1'b0, 1'b1, 8'h41, 1'b1);
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_beat_crc", a_crc, 16'hFFFF);
        check("idle_beat_busy", a_busy, 1'b0);

        // LANES=1, "123456789"
        send_msg_a();
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("a_msg_valid", a_crc_valid, 1'b1);
        check("a_msg_crc", a_crc, 16'h6F91);
        check("a_msg_busy", a_busy, 1'b0);
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("a_msg_valid_drop", a_crc_valid, 1'b0);
        check("a_msg_crc_hold", a_crc, 16'h6F91);
        check("a_msg_pulses", pulses_a, 1);

        // Restart mid-packet: aborted packet gives no pulse
        base = pulses_a;
        drive_a(1'b1, 1'b1, 8'h58, 1'b0);
        drive_a(1'b0, 1'b1, 8'h59, 1'b0);
        send_msg_a();
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("restart_valid", a_crc_valid, 1'b1);
        check("restart_crc", a_crc, 16'h6F91);
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("restart_pulses", pulses_a - base, 1);

        // Reset mid-packet overrides a coincident last beat
        base = pulses_a;
        drive_a(1'b1, 1'b1, 8'h41, 1'b0);
        drive_a(1'b0, 1'b1, 8'h42, 1'b0);
        @(negedge clk);
        rst = 1'b1; a_valid = 1'b1; a_data = 8'h43; a_last = 1'b1;
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        check("rst_abort_crc", a_crc, 16'hFFFF);
        check("rst_abort_busy", a_busy, 1'b0);
        check("rst_abort_valid", a_crc_valid, 1'b0);
        repeat (2) drive_a(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_abort_pulses", pulses_a - base, 0);

        // LANES=4, "1234","5678","9" with junk above the kept byte
        send_msg_b(16'h6F91);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("b_msg_valid", b_crc_valid, 1'b1);
        check("b_msg_crc", b_crc, 16'h6F91);
        check("b_msg_busy", b_busy, 1'b0);
`ifdef DSI_CRC_CHECK_EN
        check("b_err_match", b_err, 1'b0);
`endif
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("b_msg_valid_drop", b_crc_valid, 1'b0);
        check("b_msg_pulses", pulses_b, 1);

        // Idle beat after close leaves crc_o untouched
        drive_b(1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("b_idle_hold", b_crc, 16'h6F91);

        // keep 1011: only bytes 0 and 1 folded
        exp_crc = model(model(16'hFFFF, 8'hA1), 8'hB2);
        drive_b(1'b1, 1'b1, 32'hD4C3B2A1, 4'b1011, 1'b1);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("keep1011_crc", b_crc, exp_crc);
        check("keep1011_valid", b_crc_valid, 1'b1);

        // start alone reloads seed, then an all-zero-keep last beat closes
        drive_b(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("start_seed_crc", b_crc, 16'hFFFF);
        check("start_seed_busy", b_busy, 1'b1);
        drive_b(1'b0, 1'b1, 32'h12345678, 4'b0000, 1'b1);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("keep0_crc", b_crc, 16'hFFFF);
        check("keep0_valid", b_crc_valid, 1'b1);
        check("keep0_busy", b_busy, 1'b0);

`ifdef DSI_CRC_CHECK_EN
        // Mismatching received CRC flags an error with the valid pulse
        send_msg_b(16'h6F90);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("b_err_valid", b_crc_valid, 1'b1);
        check("b_err_mismatch", b_err, 1'b1);
        drive_b(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        check("b_err_drop", b_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_crc_engine.md
DSI_CRC_ENGINE -- requirements
Module: dsi_crc_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, legal 1..4: number of payload bytes accepted per cycle.
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  pulse; reseeds the CRC and opens a packet.
REQ-005 SHALL have port valid_i  input  1  a data beat is present this cycle.
REQ-006 SHALL have port data_i  input  8*LANES  payload; byte k in bits [8k+7:8k]; byte 0 is first on the wire.
REQ-007 SHALL have port keep_i  input  LANES  per-byte enable; bit k qualifies byte k.
REQ-008 SHALL have port last_i  input  1  qualifies the final beat of the packet.
REQ-009 SHALL have port crc_o  output  16  accumulated CRC; LSB is transmitted first.
REQ-010 SHALL have port crc_valid_o  output  1  one-cycle pulse; crc_o is final.
REQ-011 SHALL have port busy_o  output  1  high while a packet is open.

Function
REQ-012 SHALL compute the DSI checksum: CRC-16, polynomial x^16+x^12+x^5+1, reflected (0x8408), data LSB-first, seed 0xFFFF, no final XOR.
REQ-013 SHALL use the state machine IDLE -> RUN on start_i; RUN -> IDLE on an accepted beat with last_i, or on rst_i.
REQ-014 SHALL define an accepted beat as valid_i high while in RUN, or valid_i high together with start_i in any state.
REQ-015 SHALL ignore a beat with valid_i high in IDLE without start_i; neither CRC nor state changes.
REQ-016 SHALL fold the bytes of an accepted beat in ascending lane order within one cycle; all LANES byte steps are chained combinationally.
REQ-017 SHALL process only the contiguous prefix of set keep_i bits starting at bit 0; bytes at and above the first clear bit are skipped.
REQ-018 SHALL leave the CRC unchanged for an accepted beat with keep_i all zero; if that beat carries last_i, it still closes the packet.
REQ-019 SHALL seed from 0xFFFF, not from the prior CRC, when start_i coincides with a beat.
REQ-020 SHALL register crc_o; it SHALL update one cycle after each accepted beat and hold otherwise.
REQ-021 SHALL pulse crc_valid_o for exactly one cycle, one cycle after the beat carrying last_i; crc_o then holds until the next start_i.
REQ-022 SHALL abort the open packet without a crc_valid_o pulse when start_i arrives in RUN, and restart from the seed.
REQ-023 SHALL, on start_i with valid_i low, load crc_o with 0xFFFF on the next cycle and enter RUN.
REQ-024 SHALL drive busy_o high exactly while in RUN.

Reset
REQ-025 SHALL, on rst_i, on the next edge: state IDLE, crc_o 0xFFFF, crc_valid_o 0, busy_o 0, crc_err_o 0 if present; rst_i overrides all coincident inputs.
REQ-026 SHALL discard the open packet when reset arrives mid-packet; no crc_valid_o pulse follows.

Configuration
REQ-027 SHALL, with DSI_CRC_CHECK_EN defined, add input rx_crc_i (16 bits, sampled with the last beat) and output crc_err_o.
REQ-028 SHALL, with DSI_CRC_CHECK_EN defined, pulse crc_err_o together with crc_valid_o when the final CRC differs from rx_crc_i.
REQ-029 SHALL, without DSI_CRC_CHECK_EN, omit both ports and the compare logic, leaving all other behaviour identical.

Structure
REQ-030 SHALL place CRC_INIT (16'hFFFF), CRC_POLY_REFL (16'h8408) and the IDLE/RUN state encoding in the shared package dsi_crc_pkg.
REQ-031 SHALL implement the per-byte update as the combinational sub-module dsi_crc_step (crc in, byte in, enable in, crc out), instanced LANES times.

Verification
REQ-032 SHALL cover: LANES=1; start_i+valid_i with "123456789" over 9 beats, last_i on beat 9 -> crc_valid_o one cycle later, crc_o = 0x6F91.
REQ-033 SHALL cover: LANES=4; "1234","5678","9" with keep_i 4'b0001 and last_i on beat 3 -> crc_o = 0x6F91, crc_valid_o single pulse.
REQ-034 SHALL cover: start_i, then a single beat with keep_i 0 and last_i -> crc_o = 0xFFFF, crc_valid_o pulses, busy_o drops.
REQ-035 SHALL cover: restart and reset abort: start_i mid-packet, then "123456789" -> no pulse for the aborted packet, then 0x6F91; rst_i mid-packet -> crc_o 0xFFFF, busy_o 0, no pulse.
REQ-036 SHALL cover: with DSI_CRC_CHECK_EN, "123456789" with rx_crc_i = 0x6F91 -> crc_err_o 0; with rx_crc_i = 0x6F90 -> crc_err_o 1 in the crc_valid_o cycle.
REQ-037 SHALL cover: keep_i 4'b1011 on a LANES=4 beat -> only byte 0 and byte 1 are folded; matches the 2-byte reference model.
